// File: rtl/srambank_rmw_ctrl.sv
// srambank_rmw_ctrl
//   Request front-end for one synchronous single-port SRAM bank (2**AW words x DW bits).
//   - Accepts read and masked-write requests over a valid/ready handshake.
//   - Issues a full-mask write as a single SRAM write.
//   - Turns a partial-mask write into a read-modify-write.
//   - Drops an all-zero-mask write without touching the bank.
//   - Returns read data on a one-entry valid/ready response channel.
//   - With INIT_EN=1, writes zero to every word after reset before any request is taken.
//
// Ports
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we, req_addr      1 = write / 0 = read, word address
//   req_wdata, req_wmask  write data and per-bit write enable
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data, 0 while rsp_valid = 0
//   init_done             zero-init sweep complete (or never needed)
//   sram_banksel/read/write/addr/wd   bank control, address and write data
//   sram_dataout          registered read data from the bank
module srambank_rmw_ctrl #(
  parameter int AW      = 9,
  parameter int DW      = 34,
  parameter int INIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW-1:0] req_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic          sram_banksel,
  output logic          sram_read,
  output logic          sram_write,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wd,
  input  logic [DW-1:0] sram_dataout
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_RSP,
    S_WR,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  localparam state_t        S_RESET = (INIT_EN != 0) ? S_INIT : S_IDLE;
  localparam logic [AW-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Bits with mask=1 take the new data, the rest keep the stored word.
  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_d,
                                            input logic [DW-1:0] new_d,
                                            input logic [DW-1:0] mask);
    return (old_d & ~mask) | (new_d & mask);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic            r_init_done;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_wmask;

  logic            w_req_ready;
  logic            w_accept;
  logic            w_rsp_valid;
  logic [DW-1:0]   w_rsp_rdata;
  logic            w_banksel;
  logic            w_read;
  logic            w_write;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wd;

  assign w_accept = req_valid & w_req_ready;

  // State register and init sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (((r_state == S_INIT) && (r_cnt == CNT_MAX)) || (INIT_EN == 0)) begin
        r_init_done <= 1'b1;
      end
    end
  end

  // Request capture: sampled only on the accept edge, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  // Next state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_banksel   = 1'b0;
    w_read      = 1'b0;
    w_write     = 1'b0;
    w_addr      = '0;
    w_wd        = '0;
    case (r_state)
      S_INIT: begin
        w_banksel = 1'b1;
        w_write   = 1'b1;
        w_addr    = r_cnt;
        if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        // A response is never pending in IDLE, so only init_done gates acceptance.
        w_req_ready = r_init_done;
        if (w_accept) begin
          if (!req_we) begin
            w_state_nxt = S_RD;
          end else if (&req_wmask) begin
            w_state_nxt = S_WR;
          end else if (|req_wmask) begin
            w_state_nxt = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        w_banksel   = 1'b1;
        w_read      = 1'b1;
        w_addr      = r_addr;
        w_state_nxt = S_RSP;
      end
      S_RSP: begin
        // No bank read happens here, so sram_dataout is stable for the whole hold.
        w_rsp_valid = 1'b1;
        w_rsp_rdata = sram_dataout;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        w_banksel   = 1'b1;
        w_write     = 1'b1;
        w_addr      = r_addr;
        w_wd        = r_wdata;
        w_state_nxt = S_IDLE;
      end
      S_RMW_RD: begin
        w_banksel   = 1'b1;
        w_read      = 1'b1;
        w_addr      = r_addr;
        w_state_nxt = S_RMW_WR;
      end
      S_RMW_WR: begin
        w_banksel   = 1'b1;
        w_write     = 1'b1;
        w_addr      = r_addr;
        w_wd        = f_merge(sram_dataout, r_wdata, r_wmask);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  // The reset state is INIT, which would otherwise drive a bank write while
  // rst_n is low; every output is forced to 0 for as long as reset is held.
  assign req_ready    = w_req_ready & rst_n;
  assign rsp_valid    = w_rsp_valid & rst_n;
  assign rsp_rdata    = w_rsp_rdata & {DW{rst_n}};
  assign init_done    = r_init_done;
  assign sram_banksel = w_banksel & rst_n;
  assign sram_read    = w_read & rst_n;
  assign sram_write   = w_write & rst_n;
  assign sram_addr    = w_addr & {AW{rst_n}};
  assign sram_wd      = w_wd & {DW{rst_n}};

endmodule

// File: tb/tb_srambank_rmw_ctrl.sv
module tb_srambank_rmw_ctrl;
  localparam int AW = 9;
  localparam int DW = 34;
  localparam logic [DW-1:0] ONES = '1;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_banksel;
  logic          sram_read;
  logic          sram_write;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wd;
  logic [DW-1:0] sram_dataout;

  int n_vec = 0;
  int n_bad = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  srambank_rmw_ctrl #(.AW(AW), .DW(DW), .INIT_EN(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wmask    (req_wmask),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .init_done    (init_done),
    .sram_banksel (sram_banksel),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_addr    (sram_addr),
    .sram_wd      (sram_wd),
    .sram_dataout (sram_dataout)
  );

  // Behavioural model of the synchronous bank: registered read port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q = '0;
  assign sram_dataout = dout_q;
  always @(posedge clk) begin
    if (sram_banksel && sram_write) mem[sram_addr] <= sram_wd;
    if (sram_banksel && sram_read)  dout_q <= mem[sram_addr];
  end

  always @(negedge clk) begin
    if (sram_read && sram_write) overlap++;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] exp;   // read: expected rsp_rdata; write: expected sram_wd
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present a request at a negedge, let it be accepted, then scramble the inputs.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m, input string nm);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    chk({nm, "_ready_at_accept"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d; req_wmask = ~m;
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    do_req(v.we, v.addr, v.wdata, v.wmask, tag);
    if (!v.we) begin
      chk({tag, "_rd_pins"}, {sram_banksel, sram_read, sram_write}, 3'b110);
      chk({tag, "_rd_addr"}, sram_addr, v.addr);
      chk({tag, "_rsp_early"}, rsp_valid, 0);
      @(negedge clk);
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp);
      chk({tag, "_rsp_nobank"}, sram_banksel, 0);
      @(negedge clk);
    end else if (v.wmask == ONES) begin
      chk({tag, "_wr_pins"}, {sram_banksel, sram_read, sram_write}, 3'b101);
      chk({tag, "_wr_addr"}, sram_addr, v.addr);
      chk({tag, "_wr_wd"}, sram_wd, v.exp);
      @(negedge clk);
    end else if (v.wmask == '0) begin
      chk({tag, "_nomask_nobank"}, sram_banksel, 0);
    end else begin
      chk({tag, "_rmw_rd_pins"}, {sram_banksel, sram_read, sram_write}, 3'b110);
      chk({tag, "_rmw_rd_addr"}, sram_addr, v.addr);
      @(negedge clk);
      chk({tag, "_rmw_wr_pins"}, {sram_banksel, sram_read, sram_write}, 3'b101);
      chk({tag, "_rmw_wr_addr"}, sram_addr, v.addr);
      chk({tag, "_rmw_wd"}, sram_wd, v.exp);
      @(negedge clk);
    end
    chk({tag, "_idle_ready"}, req_ready, 1);
    chk({tag, "_idle_rsp"}, {rsp_valid, rsp_rdata}, 0);
  endtask

  // Called right after rst_n is released at a negedge.
  task automatic init_sweep(input string nm);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b1;
    #1;
    for (int c = 0; c < 600; c++) begin
      if (!(sram_banksel && sram_write)) break;
      if (sram_addr !== n[AW-1:0] || sram_wd !== '0 || sram_read !== 1'b0 ||
          init_done !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({nm, "_write_cycles"}, n, 512);
    chk({nm, "_addr_seq_wd0"}, ok, 1);
    chk({nm, "_init_done"}, init_done, 1);
    chk({nm, "_req_ready"}, req_ready, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {sram_banksel, sram_read, sram_write, req_ready, rsp_valid, init_done}, 0);
    chk({nm, "_addr"}, sram_addr, 0);
    chk({nm, "_wd"}, sram_wd, 0);
    chk({nm, "_rdata"}, rsp_rdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 9'h1A5, 34'h2DEADBEEF, ONES,           34'h2DEADBEEF};
    vecs[1]  = '{1'b0, 9'h1A5, 34'h0,         34'h0,          34'h2DEADBEEF};
    vecs[2]  = '{1'b1, 9'h007, 34'h3FFFFFFFF, ONES,           34'h3FFFFFFFF};
    vecs[3]  = '{1'b1, 9'h007, 34'h0,         34'h0000000FF,  34'h3FFFFFF00};
    vecs[4]  = '{1'b0, 9'h007, 34'h0,         34'h0,          34'h3FFFFFF00};
    vecs[5]  = '{1'b1, 9'h003, 34'h155555555, ONES,           34'h155555555};
    vecs[6]  = '{1'b1, 9'h003, 34'h0AAAAAAAA, 34'h0,          34'h0};
    vecs[7]  = '{1'b0, 9'h003, 34'h0,         34'h0,          34'h155555555};
    vecs[8]  = '{1'b0, 9'h000, 34'h0,         34'h0,          34'h0};
    vecs[9]  = '{1'b0, 9'h1FF, 34'h0,         34'h0,          34'h0};
    vecs[10] = '{1'b1, 9'h1FF, 34'h2AAAAAAAA, 34'h30000000F,  34'h20000000A};
    vecs[11] = '{1'b0, 9'h1FF, 34'h0,         34'h0,          34'h20000000A};
    vecs[12] = '{1'b1, 9'h1A5, 34'h100000001, 34'h300000000,  34'h1DEADBEEF};
    vecs[13] = '{1'b0, 9'h1A5, 34'h0,         34'h0,          34'h1DEADBEEF};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;

    // Outputs held at 0 during reset, then the zero-init sweep.
    @(negedge clk); @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    init_sweep("init");

    // Table of reads, full writes, masked RMW writes and zero-mask writes.
    for (int i = 0; i < NV; i++) begin
      apply_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Response held while the consumer stalls.
    rsp_ready = 1'b0;
    do_req(1'b0, 9'h1A5, 34'h0, 34'h0, "hold");
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_valid", k), rsp_valid, 1);
      chk($sformatf("hold%0d_rdata", k), rsp_rdata, 34'h1DEADBEEF);
      chk($sformatf("hold%0d_ready", k), req_ready, 0);
      chk($sformatf("hold%0d_nobank", k), sram_banksel, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", rsp_valid, 0);
    chk("hold_release_rdata", rsp_rdata, 0);
    chk("hold_release_ready", req_ready, 1);

    // Reset asserted in the middle of a read-modify-write.
    do_req(1'b1, 9'h010, 34'h0, 34'h000000001, "rst");
    chk("rst_in_rmw_rd", {sram_banksel, sram_read, sram_write}, 3'b110);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    init_sweep("reinit");

    // Previously written word is zero again after the rerun sweep.
    v = '{1'b0, 9'h1A5, 34'h0, 34'h0, 34'h0};
    apply_vec(v, "post_reinit");

    chk("rd_wr_exclusive", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
